core_sched: RTL and testbench
=============================

CORE_SCHED -- requirements
Module: core_sched

Interface
REQ-001 Parameter NUM_CORES, default 2, number of processing cores served (supported range 2-4).
REQ-002 Parameter ADDR_WIDTH, default 8, packet-memory address width.
REQ-003 Parameter DESC_DEPTH, default 4, descriptor FIFO depth (power of two).
REQ-004 The block SHALL use a single clock, clk, and a synchronous active-high reset, reset; all state SHALL change only on the rising edge of clk.
REQ-005 clk  in  1  system clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 packet_rdy  in  1  one-cycle pulse: a complete packet is stored in packet memory.
REQ-008 packet_start_addr  in  ADDR_WIDTH  first word address of that packet.
REQ-009 packet_end_addr  in  ADDR_WIDTH  last word address of that packet.
REQ-010 desc_full  out  1  descriptor FIFO full (registered).
REQ-011 desc_ovf  out  1  sticky flag: a descriptor was dropped.
REQ-012 core_en  out  NUM_CORES  per-core run enable.
REQ-013 core_start_addr  out  NUM_CORES*ADDR_WIDTH  per-core start address; core i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-014 core_end_addr  out  NUM_CORES*ADDR_WIDTH  per-core end address; packed the same way.
REQ-015 core_done  in  NUM_CORES  per-core completion pulse.
REQ-016 mem_req  in  NUM_CORES  per-core request for the shared packet-memory port.
REQ-017 mem_gnt  out  NUM_CORES  one-hot grant for the shared port (registered).
REQ-018 proc_done  out  1  one-cycle pulse: a packet is retired and may be sent out.
REQ-019 done_start_addr / done_end_addr  out  ADDR_WIDTH each  descriptor of the retired packet; valid while proc_done is high.
REQ-020 pkt_count  out  16  number of packets retired.

Function
REQ-021 Descriptor FIFO: on packet_rdy with desc_full low, {start,end} SHALL be written at that edge; with desc_full high it SHALL be dropped and desc_ovf set.
REQ-022 A push and a pop in the same cycle SHALL both take effect when the FIFO is not full; occupancy is then unchanged.
REQ-023 FIFO read and write pointers SHALL wrap modulo DESC_DEPTH.
REQ-024 Each core SHALL have its own FSM with states IDLE, RUN and DONE.
REQ-025 IDLE->RUN on dispatch; RUN->DONE on an edge where core_done[i] is high; DONE->IDLE on retire.
REQ-026 core_done[i] SHALL be ignored in IDLE and DONE.
REQ-027 core_en[i] SHALL be high exactly while core i is in RUN.
REQ-028 The core's address outputs SHALL be loaded at dispatch and held until its next dispatch.
REQ-029 Dispatch: at most one per cycle, when the FIFO is non-empty and at least one core is IDLE.
REQ-030 The dispatch target SHALL be the first IDLE core searching upward from rr_disp, wrapping; rr_disp (reset 0) SHALL then become target+1 mod NUM_CORES.
REQ-031 Latency: a descriptor pushed at edge t with an idle core SHALL be popped at edge t+1, so core_en rises after t+1.
REQ-032 An order FIFO (depth NUM_CORES) SHALL record the dispatched core index at each dispatch.
REQ-033 Retire: when the core at the order-FIFO head is in DONE, the block SHALL, at that edge, pulse proc_done for one cycle, output that core's descriptor, return the core to IDLE, pop the order FIFO and increment pkt_count (wraps at 0xFFFF).
REQ-034 Retirement SHALL follow dispatch order; a core finishing early SHALL wait in DONE.
REQ-035 A core returned to IDLE at edge e SHALL be eligible for dispatch from edge e+1.
REQ-036 Memory arbiter: when no grant is held, the first requester searching from rr_mem (reset 0) SHALL be granted at the next edge; rr_mem SHALL then become grantee+1.
REQ-037 A grant SHALL be held while the grantee keeps mem_req high and SHALL clear at the edge after its mem_req falls.
REQ-038 No new grant SHALL be issued in the cycle a grant clears.
REQ-039 mem_gnt SHALL never have more than one bit set.

Reset
REQ-040 Reset SHALL force: all FSMs to IDLE; both FIFOs empty; rr_disp = rr_mem = 0.
REQ-041 Reset SHALL force all of these outputs to 0: core_en, mem_gnt, proc_done, desc_full, desc_ovf, pkt_count, and all address outputs.
REQ-042 Reset mid-operation SHALL discard all in-flight descriptors without asserting proc_done.

Verification
REQ-043 Single packet (0x10,0x1F): core_en=01 two edges after the push; core_done[0] pulse -> proc_done one edge after DONE, done_start_addr=0x10, done_end_addr=0x1F, pkt_count=1.
REQ-044 Out-of-order finish: packets A then B go to cores 0 and 1; core 1 finishes first -> proc_done for A first, then B the next cycle.
REQ-045 Overflow: both cores busy, 5 pushes with DESC_DEPTH=4 -> desc_full=1 after the 4th push, desc_ovf=1, FIFO holds 4 descriptors.
REQ-046 Arbitration: mem_req=11 from reset -> mem_gnt=01 held until req[0] drops, one idle cycle, then mem_gnt=10.
REQ-047 Reset asserted with 2 cores in RUN and 2 descriptors queued -> next cycle all outputs 0, no proc_done pulse; a new push is dispatched to core 0.

Source files
------------

// File: rtl/core_sched.sv
// Packet scheduler: descriptor FIFO, per-core IDLE/RUN/DONE FSMs retired in dispatch
// order, and a round-robin arbiter for the shared packet-memory port.
module core_sched #(
  parameter int NUM_CORES  = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DESC_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            packet_rdy,
  input  logic [ADDR_WIDTH-1:0]           packet_start_addr,
  input  logic [ADDR_WIDTH-1:0]           packet_end_addr,
  output logic                            desc_full,
  output logic                            desc_ovf,
  output logic [NUM_CORES-1:0]            core_en,
  output logic [NUM_CORES*ADDR_WIDTH-1:0] core_start_addr,
  output logic [NUM_CORES*ADDR_WIDTH-1:0] core_end_addr,
  input  logic [NUM_CORES-1:0]            core_done,
  input  logic [NUM_CORES-1:0]            mem_req,
  output logic [NUM_CORES-1:0]            mem_gnt,
  output logic                            proc_done,
  output logic [ADDR_WIDTH-1:0]           done_start_addr,
  output logic [ADDR_WIDTH-1:0]           done_end_addr,
  output logic [15:0]                     pkt_count
);
  localparam int CW = $clog2(NUM_CORES);
  localparam int PW = $clog2(DESC_DEPTH);
  localparam int OW = $clog2(NUM_CORES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  logic [2*ADDR_WIDTH-1:0] desc_mem_q [DESC_DEPTH];
  logic [2*ADDR_WIDTH-1:0] desc_head;
  logic [PW-1:0]           dwr_q, drd_q;
  logic [PW:0]             dcnt_q, dcnt_d;
  logic                    full_q, ovf_q, push;

  state_t                               state_q [NUM_CORES];
  state_t                               state_d [NUM_CORES];
  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] csa_q, cea_q;

  logic [CW-1:0] rr_disp_q, dcand, disp_idx;
  logic          disp_vld;

  logic [CW-1:0] ord_mem_q [NUM_CORES];
  logic [CW-1:0] owr_q, ordrd_q, head;
  logic [OW-1:0] ocnt_q;
  logic          retire;

  logic [NUM_CORES-1:0] gnt_q, gnt_d;
  logic [CW-1:0]        rr_mem_q, rr_mem_d, mcand;
  logic                 mfound;

  logic                  pdone_q;
  logic [ADDR_WIDTH-1:0] dsa_q, dea_q;
  logic [15:0]           pcnt_q;

  function automatic logic [CW-1:0] inc_core(input logic [CW-1:0] v);
    return (v == CW'(NUM_CORES - 1)) ? '0 : v + 1'b1;
  endfunction

  assign push      = packet_rdy & ~full_q;
  assign desc_head = desc_mem_q[drd_q];
  assign head      = ord_mem_q[ordrd_q];
  assign retire    = (ocnt_q != '0) && (state_q[head] == S_DONE);

  always_comb begin
    dcnt_d = dcnt_q;
    case ({push, disp_vld})
      2'b10:   dcnt_d = dcnt_q + 1'b1;
      2'b01:   dcnt_d = dcnt_q - 1'b1;
      default: dcnt_d = dcnt_q;
    endcase
  end

  // Dispatch target: first IDLE core at or after rr_disp, wrapping
  always_comb begin
    disp_vld = 1'b0;
    disp_idx = rr_disp_q;
    dcand    = rr_disp_q;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!disp_vld && state_q[dcand] == S_IDLE) begin
        disp_vld = 1'b1;
        disp_idx = dcand;
      end
      dcand = inc_core(dcand);
    end
    if (dcnt_q == '0) disp_vld = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORES; i++) state_q[i] <= S_IDLE;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) state_q[i] <= state_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        S_IDLE:  if (disp_vld && disp_idx == CW'(i)) state_d[i] = S_RUN;
        S_RUN:   if (core_done[i]) state_d[i] = S_DONE;
        S_DONE:  if (retire && head == CW'(i)) state_d[i] = S_IDLE;
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) core_en[i] = (state_q[i] == S_RUN);
  end

  // A held grant only clears; a new grant waits for a cycle with no grant
  always_comb begin
    gnt_d    = gnt_q;
    rr_mem_d = rr_mem_q;
    mfound   = 1'b0;
    mcand    = rr_mem_q;
    if (gnt_q != '0) begin
      if ((gnt_q & mem_req) == '0) gnt_d = '0;
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        if (!mfound && mem_req[mcand]) begin
          mfound        = 1'b1;
          gnt_d         = '0;
          gnt_d[mcand]  = 1'b1;
          rr_mem_d      = inc_core(mcand);
        end
        mcand = inc_core(mcand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dwr_q     <= '0;
      drd_q     <= '0;
      dcnt_q    <= '0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      csa_q     <= '0;
      cea_q     <= '0;
      rr_disp_q <= '0;
      owr_q     <= '0;
      ordrd_q   <= '0;
      ocnt_q    <= '0;
      gnt_q     <= '0;
      rr_mem_q  <= '0;
      pdone_q   <= 1'b0;
      dsa_q     <= '0;
      dea_q     <= '0;
      pcnt_q    <= '0;
    end else begin
      if (push) begin
        desc_mem_q[dwr_q] <= {packet_start_addr, packet_end_addr};
        dwr_q             <= dwr_q + 1'b1;
      end
      if (packet_rdy && full_q) ovf_q <= 1'b1;
      dcnt_q <= dcnt_d;
      full_q <= (dcnt_d == (PW+1)'(DESC_DEPTH));
      if (disp_vld) begin
        drd_q             <= drd_q + 1'b1;
        csa_q[disp_idx]   <= desc_head[2*ADDR_WIDTH-1:ADDR_WIDTH];
        cea_q[disp_idx]   <= desc_head[ADDR_WIDTH-1:0];
        rr_disp_q         <= inc_core(disp_idx);
        ord_mem_q[owr_q]  <= disp_idx;
        owr_q             <= inc_core(owr_q);
      end
      case ({disp_vld, retire})
        2'b10:   ocnt_q <= ocnt_q + 1'b1;
        2'b01:   ocnt_q <= ocnt_q - 1'b1;
        default: ocnt_q <= ocnt_q;
      endcase
      pdone_q <= retire;
      if (retire) begin
        dsa_q   <= csa_q[head];
        dea_q   <= cea_q[head];
        ordrd_q <= inc_core(ordrd_q);
        pcnt_q  <= pcnt_q + 1'b1;
      end
      gnt_q    <= gnt_d;
      rr_mem_q <= rr_mem_d;
    end
  end

  assign desc_full       = full_q;
  assign desc_ovf        = ovf_q;
  assign core_start_addr = csa_q;
  assign core_end_addr   = cea_q;
  assign mem_gnt         = gnt_q;
  assign proc_done       = pdone_q;
  assign done_start_addr = dsa_q;
  assign done_end_addr   = dea_q;
  assign pkt_count       = pcnt_q;

endmodule

// File: tb/tb_core_sched.sv
// Scoreboarded bench for core_sched: retirements are queued at push time and
// matched by a monitor whenever proc_done is seen.
module tb_core_sched;
  localparam int NC = 2;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          packet_rdy;
  logic [AW-1:0] packet_start_addr, packet_end_addr;
  logic          desc_full, desc_ovf;
  logic [NC-1:0] core_en, core_done, mem_req, mem_gnt;
  logic [NC*AW-1:0] core_start_addr, core_end_addr;
  logic          proc_done;
  logic [AW-1:0] done_start_addr, done_end_addr;
  logic [15:0]   pkt_count;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0]  s;
    logic [7:0]  e;
    logic [15:0] n;
  } exp_t;
  exp_t sb[$];
  exp_t mon_x;

  core_sched #(.NUM_CORES(NC), .ADDR_WIDTH(AW), .DESC_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .packet_rdy(packet_rdy),
    .packet_start_addr(packet_start_addr), .packet_end_addr(packet_end_addr),
    .desc_full(desc_full), .desc_ovf(desc_ovf), .core_en(core_en),
    .core_start_addr(core_start_addr), .core_end_addr(core_end_addr),
    .core_done(core_done), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .proc_done(proc_done), .done_start_addr(done_start_addr),
    .done_end_addr(done_end_addr), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one-hot grant every cycle, and each proc_done against the scoreboard
  always @(negedge clk) begin
    check("gnt_onehot", ($countones(mem_gnt) <= 1) ? 32'd1 : 32'd0, 32'd1);
    if (proc_done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_proc_done", {16'd0, pkt_count}, 32'hFFFF_FFFF);
      end else begin
        mon_x = sb.pop_front();
        check("ret_start", {24'd0, done_start_addr}, {24'd0, mon_x.s});
        check("ret_end", {24'd0, done_end_addr}, {24'd0, mon_x.e});
        check("ret_count", {16'd0, pkt_count}, {16'd0, mon_x.n});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [7:0] s, input logic [7:0] e);
    packet_rdy        = 1'b1;
    packet_start_addr = s;
    packet_end_addr   = e;
    tick();
    packet_rdy = 1'b0;
  endtask

  task automatic expect_ret(input logic [7:0] s, input logic [7:0] e, input logic [15:0] n);
    exp_t x;
    x.s = s;
    x.e = e;
    x.n = n;
    sb.push_back(x);
  endtask

  task automatic pulse_done(input logic [NC-1:0] d);
    core_done = d;
    tick();
    core_done = '0;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_full"}, {31'd0, desc_full}, 32'd0);
    check({tag, "_ovf"}, {31'd0, desc_ovf}, 32'd0);
    check({tag, "_core_en"}, {30'd0, core_en}, 32'd0);
    check({tag, "_gnt"}, {30'd0, mem_gnt}, 32'd0);
    check({tag, "_proc_done"}, {31'd0, proc_done}, 32'd0);
    check({tag, "_pkt_count"}, {16'd0, pkt_count}, 32'd0);
    check({tag, "_core_addr"}, {core_start_addr, core_end_addr}, 32'd0);
    check({tag, "_done_addr"}, {16'd0, done_start_addr, done_end_addr}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; packet_rdy = 1'b0; packet_start_addr = '0; packet_end_addr = '0;
    core_done = '0; mem_req = '0;
    do_reset();
    chk_zero("rst");

    // Single packet
    expect_ret(8'h10, 8'h1F, 16'd1);
    push(8'h10, 8'h1F);
    check("single_en_t0", {30'd0, core_en}, 32'd0);
    tick();
    check("single_en_t1", {30'd0, core_en}, 32'd1);
    check("single_core_addr", {16'd0, core_start_addr[7:0], core_end_addr[7:0]}, 32'h101F);
    pulse_done(2'b01);
    check("single_en_done", {30'd0, core_en}, 32'd0);
    check("single_pd_early", {31'd0, proc_done}, 32'd0);
    tick();
    check("single_pd", {31'd0, proc_done}, 32'd1);
    check("single_cnt", {16'd0, pkt_count}, 32'd1);
    tick();
    check("single_pd_off", {31'd0, proc_done}, 32'd0);

    // Out-of-order finish, retirement stays in dispatch order
    do_reset();
    expect_ret(8'h20, 8'h2F, 16'd1);
    expect_ret(8'h30, 8'h3F, 16'd2);
    push(8'h20, 8'h2F);
    push(8'h30, 8'h3F);
    tick();
    check("ooo_en_both", {30'd0, core_en}, 32'd3);
    check("ooo_core1_addr", {16'd0, core_start_addr[15:8], core_end_addr[15:8]}, 32'h303F);
    pulse_done(2'b10);
    check("ooo_en_c0", {30'd0, core_en}, 32'd1);
    tick();
    check("ooo_wait", {31'd0, proc_done}, 32'd0);
    pulse_done(2'b01);
    tick();
    check("ooo_first", {24'd0, done_start_addr}, 32'h20);
    tick();
    check("ooo_second", {24'd0, done_start_addr}, 32'h30);
    check("ooo_cnt", {16'd0, pkt_count}, 32'd2);
    tick();
    check("ooo_idle", {30'd0, core_en}, 32'd0);
    pulse_done(2'b11);
    tick();
    check("idle_done_ignored", {31'd0, proc_done}, 32'd0);
    expect_ret(8'h70, 8'h7F, 16'd3);
    push(8'h70, 8'h7F);
    tick();
    check("after_ignore_en", {30'd0, core_en}, 32'd1);
    pulse_done(2'b01);
    tick();
    check("after_ignore_cnt", {16'd0, pkt_count}, 32'd3);

    // Overflow: both cores busy, five more pushes, fifth dropped
    do_reset();
    for (int i = 0; i < 6; i++)
      expect_ret(8'h80 + 8'(i * 16), 8'h8F + 8'(i * 16), 16'(i + 1));
    push(8'h80, 8'h8F);
    push(8'h90, 8'h9F);
    tick();
    check("ovf_busy", {30'd0, core_en}, 32'd3);
    push(8'hA0, 8'hAF);
    push(8'hB0, 8'hBF);
    push(8'hC0, 8'hCF);
    check("ovf_full_3", {31'd0, desc_full}, 32'd0);
    push(8'hD0, 8'hDF);
    check("ovf_full_4", {31'd0, desc_full}, 32'd1);
    check("ovf_flag_pre", {31'd0, desc_ovf}, 32'd0);
    push(8'hE0, 8'hEF);
    check("ovf_flag", {31'd0, desc_ovf}, 32'd1);
    check("ovf_full_5", {31'd0, desc_full}, 32'd1);
    for (int r = 0; r < 3; r++) begin
      pulse_done(2'b11);
      for (int j = 0; j < 4; j++) tick();
    end
    check("ovf_drained_full", {31'd0, desc_full}, 32'd0);
    check("ovf_sticky", {31'd0, desc_ovf}, 32'd1);
    check("ovf_drained_cnt", {16'd0, pkt_count}, 32'd6);
    check("ovf_drained_en", {30'd0, core_en}, 32'd0);

    // Arbitration
    reset = 1'b1;
    mem_req = 2'b11;
    tick();
    reset = 1'b0;
    tick();
    check("arb_first", {30'd0, mem_gnt}, 32'd1);
    tick();
    tick();
    check("arb_hold", {30'd0, mem_gnt}, 32'd1);
    mem_req = 2'b10;
    tick();
    check("arb_gap", {30'd0, mem_gnt}, 32'd0);
    tick();
    check("arb_second", {30'd0, mem_gnt}, 32'd2);
    mem_req = 2'b00;
    tick();
    check("arb_release", {30'd0, mem_gnt}, 32'd0);
    mem_req = 2'b11;
    tick();
    check("arb_rr_wrap", {30'd0, mem_gnt}, 32'd1);
    mem_req = 2'b00;
    tick();

    // Reset mid-operation
    do_reset();
    push(8'h40, 8'h4F);
    push(8'h50, 8'h5F);
    tick();
    push(8'h60, 8'h6F);
    push(8'h61, 8'h6E);
    check("mid_busy", {30'd0, core_en}, 32'd3);
    reset = 1'b1;
    tick();
    chk_zero("mid_rst");
    reset = 1'b0;
    tick();
    tick();
    check("mid_no_dispatch", {30'd0, core_en}, 32'd0);
    expect_ret(8'h66, 8'h6F, 16'd1);
    push(8'h66, 8'h6F);
    tick();
    check("mid_new_core0", {30'd0, core_en}, 32'd1);
    check("mid_new_addr", {24'd0, core_start_addr[7:0]}, 32'h66);
    pulse_done(2'b01);
    tick();
    tick();

    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
